// File: rtl/merge_3.sv
// Three-way result join: accepts branch results strictly in dispatch order
// and forwards them over a four-phase handshake to the writeback channel.
module merge_3 #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                disp_valid,
  input  logic [1:0]          disp_branch,
  output logic                q_full,
  input  logic [2:0]          req_in,
  input  logic [3*DATA_W-1:0] data_in,
  output logic [2:0]          ack_out,
  output logic                req_out,
  output logic [DATA_W-1:0]   data_out,
  input  logic                ack_in,
  output logic                err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  state_e                       state_q;
  logic [SYNC_STAGES-1:0][2:0]  req_sync_q;
  logic [SYNC_STAGES-1:0]       ack_sync_q;
  logic [1:0]                   fifo_q [DEPTH];
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                count_q, count_d;
  logic [2:0]                   ack_q;
  logic                         req_q, err_q, err_d, q_full_q;
  logic [DATA_W-1:0]            data_q;

  logic [2:0]        req_s;
  logic              ack_s;
  logic [1:0]        head;
  logic              empty, full, push, pop, head_req;
  logic [DATA_W-1:0] head_data;

  assign req_s    = req_sync_q[SYNC_STAGES-1];
  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign ack_out  = ack_q;
  assign req_out  = req_q;
  assign data_out = data_q;
  assign err      = err_q;
  assign q_full   = q_full_q;

  always_comb begin
    head      = fifo_q[rd_ptr_q];
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    push      = disp_valid && !full && (disp_branch != 2'd3);
    head_req  = req_s[head];
    pop       = (state_q == DRAIN) && !ack_s && !head_req;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // Illegal dispatches and requests with nothing outstanding are both flagged.
    err_d     = err_q
              | (disp_valid && (full || (disp_branch == 2'd3)))
              | ((|req_s) && empty && (state_q == IDLE));
    case (head)
      2'd0:    head_data = data_in[0*DATA_W +: DATA_W];
      2'd1:    head_data = data_in[1*DATA_W +: DATA_W];
      default: head_data = data_in[2*DATA_W +: DATA_W];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_in};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_full_q <= 1'b0;
      ack_q    <= '0;
      req_q    <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      q_full_q <= (count_d == CW'(DEPTH));
      err_q    <= err_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= disp_branch;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case (state_q)
        IDLE: begin
          if (!empty && head_req) begin
            data_q  <= head_data;
            ack_q   <= 3'b001 << head;
            req_q   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            ack_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
